// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// The result registers only change on completion, so a downstream display never sees partial shifts.
module bin_to_bcd_converter #(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       bin_in,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [NUM_DIGITS-1:0][3:0] bcd_out
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
    localparam int          CW    = $clog2(BIN_WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                     state_q, state_d;
    logic [BIN_WIDTH-1:0]       shift_q, shift_d;
    logic [NUM_DIGITS-1:0][3:0] scratch_q, scratch_d;
    logic [NUM_DIGITS-1:0][3:0] adj;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       ovf_pend_q, ovf_pend_d;
    logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic                       ovf_q, ovf_d;
    logic                       done_q, done_d;
    logic [63:0]                bin_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        bin_ext    = 64'(bin_in);

        // Add-3 correction is applied before the shift so each digit stays in 0..9 after doubling
        adj = scratch_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch_q[i] >= 4'd5) begin
                adj[i] = scratch_q[i] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CW'(BIN_WIDTH);
                    ovf_pend_d = (bin_ext >= LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = (NUM_DIGITS * 4)'({adj, shift_q[BIN_WIDTH-1]});
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (ovf_pend_q) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            bcd_d[i] = 4'd9;
                        end
                    end else begin
                        bcd_d = scratch_d;
                    end
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;

endmodule
